// File: rtl/handshake_pkg.sv
// handshake_pkg: shared types and constants for the handshake source controller
package handshake_pkg;
  localparam int DEF_WIDTH = 30;
  localparam int TX_CNT_W = 16;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
endpackage

// File: rtl/handshake_src_ctrl_if.sv
// handshake_src_ctrl_if: upstream stream, synchronizer request side and status of the source controller
interface handshake_src_ctrl_if
  import handshake_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic sready;
  logic [WIDTH-1:0] din;
  logic sidle;
  logic busy;
  logic [TX_CNT_W-1:0] tx_count;
  logic timeout_err;
  modport master (
    input in_valid, in_data, sidle,
    output in_ready, sready, din, busy, tx_count, timeout_err
  );
  modport slave (
    output in_valid, in_data, sidle,
    input in_ready, sready, din, busy, tx_count, timeout_err
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head and extra-MSB pointers
module sync_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [WIDTH-1:0] wdata,
  input  logic pop,
  output logic [WIDTH-1:0] rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
    end
  end
  assign rdata = mem[rp[AW-1:0]];
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
endmodule

// File: rtl/handshake_src_ctrl.sv
// handshake_src_ctrl: queues an upstream word stream and offers it to the handshake synchronizer one word at a time
module handshake_src_ctrl
  import handshake_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  handshake_src_ctrl_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_nx;
  logic [CW-1:0] wcnt, wcnt_nx;
  logic [WIDTH-1:0] head, din;
  logic [TX_CNT_W-1:0] tx_cnt;
  logic full, empty, pop, done, sready, timeout_err;
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(bus.in_valid && !full),
    .wdata(bus.in_data),
    .pop(pop),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  // wcnt is zero only on the first WAIT cycle, which masks sidle while sreq rises
  always_comb begin
    pop = state == IDLE && !empty && bus.sidle;
    done = state == WAIT && wcnt != '0 && bus.sidle;
    state_nx = pop ? SEND : state == SEND ? WAIT : done ? IDLE : state;
    wcnt_nx = state == SEND ? '0 : (state == WAIT && !done && wcnt != CW'(TIMEOUT)) ? wcnt + 1'b1 : wcnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wcnt <= '0;
    end else begin
      state <= state_nx;
      wcnt <= wcnt_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sready <= 1'b0;
      din <= '0;
      tx_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      sready <= pop;
      din <= pop ? head : din;
      tx_cnt <= tx_cnt + TX_CNT_W'(done);
      timeout_err <= timeout_err || (state == WAIT && wcnt == CW'(TIMEOUT));
    end
  end
  assign bus.in_ready = !full;
  assign bus.sready = sready;
  assign bus.din = din;
  assign bus.busy = state != IDLE || !empty;
  assign bus.tx_count = tx_cnt;
  assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_handshake_src_ctrl.sv
// tb_handshake_src_ctrl: directed and random stimulus checked against a transfer-level reference model
module tb_handshake_src_ctrl;
  localparam int W = 30;
  localparam int D = 4;
  localparam int T = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  handshake_src_ctrl_if #(.WIDTH(W)) bus ();
  handshake_src_ctrl #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [W-1:0] up[$];
  logic [W-1:0] mq[$];
  bit m_idle = 1'b1;
  int age = 0;
  logic m_sready = 1'b0;
  logic [W-1:0] m_din = '0;
  logic [15:0] m_cnt = '0;
  logic m_err = 1'b0;
  logic prev_sready = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // age = index of the current WAIT cycle (1 = guard cycle)
  task automatic model(input logic r, input logic s);
    bit acc, was_send;
    if (r) begin
      mq.delete();
      m_idle = 1'b1;
      age = 0;
      m_sready = 1'b0;
      m_din = '0;
      m_cnt = '0;
      m_err = 1'b0;
    end else begin
      acc = up.size() > 0 && mq.size() < D;
      was_send = m_sready;
      m_sready = 1'b0;
      if (m_idle) begin
        if (mq.size() > 0 && s) begin
          m_din = mq.pop_front();
          m_sready = 1'b1;
          m_idle = 1'b0;
        end
      end else if (was_send) age = 1;
      else begin
        if (age >= T + 1) m_err = 1'b1;
        if (age >= 2 && s) begin
          m_idle = 1'b1;
          m_cnt++;
        end else age++;
      end
      if (acc) mq.push_back(up.pop_front());
    end
  endtask

  task automatic tick(input logic r, input logic s);
    rst = r;
    bus.sidle = s;
    bus.in_valid = up.size() > 0;
    bus.in_data = up.size() > 0 ? up[0] : '0;
    @(posedge clk);
    model(r, s);
    @(negedge clk);
    chk("sready", 32'(bus.sready), 32'(m_sready));
    chk("din", 32'(bus.din), 32'(m_din));
    chk("tx_count", 32'(bus.tx_count), 32'(m_cnt));
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
    chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < D));
    chk("busy", 32'(bus.busy), 32'(!m_idle || mq.size() > 0));
    chk("sready_twice", 32'(prev_sready && bus.sready), 32'd0);
    prev_sready = bus.sready;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (!m_idle || mq.size() > 0 || up.size() > 0); i++) tick(1'b0, 1'b1);
    chk("drain_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.sidle = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    up.push_back(30'h2AAA_5555);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    chk("single_count", 32'(bus.tx_count), 32'd1);
    drain();
    for (int i = 0; i < 5; i++) up.push_back(W'(32'h1000 + i));
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b1);
    drain();
    up.push_back(30'h0123_4567);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
    drain();
    up.push_back(30'h3FFF_0001);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    chk("timeout_sticky", 32'(bus.timeout_err), 32'd1);
    drain();
    for (int i = 0; i < 3; i++) up.push_back(W'(32'h2000 + i));
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    drain();
    force dut.tx_cnt = 16'hFFFF;
    #1 release dut.tx_cnt;
    m_cnt = 16'hFFFF;
    up.push_back(30'h1555_AAAA);
    drain();
    chk("wrap", 32'(bus.tx_count), 32'd0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0 && up.size() < 3) up.push_back(W'($urandom));
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
